// File: rtl/auto_nav_pkg.sv
// Shared types for the auto_nav_ctrl line-follower navigator: state codes,
// turn directions and history entry codes.
package auto_nav_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WAIT  = 3'd3,
    ST_TURN  = 3'd4,
    ST_UTURN = 3'd5
  } nav_state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    HIST_NONE = 2'b00,
    HIST_L    = 2'b01,
    HIST_R    = 2'b10,
    HIST_U    = 2'b11
  } hist_code_e;

  function automatic hist_code_e dir_to_hist(input dir_e dir);
    return (dir == DIR_LEFT) ? HIST_L : HIST_R;
  endfunction

endpackage

// File: rtl/det_filter.sv
// One barrier detector: 2-FF synchroniser followed by a tick-based debounce
// that adopts a new level only after STABLE_MS ticks of it being held.
module det_filter #(
  parameter int STABLE_MS = 50
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic tick,
  input  logic det_raw,
  output logic det_filt
);

  localparam int CW = $clog2(STABLE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_MS - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;
  logic          raw;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sync_d = {sync_q[0], det_raw};
    raw    = sync_q[1];
    filt_d = filt_q;
    cnt_d  = cnt_q;
    // A one-bit raw value that flips while differing must now equal the filtered
    // value, so clearing on equality is what restarts the count on any change.
    if (raw == filt_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = raw;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign det_filt = filt_q;

endmodule

// File: rtl/auto_nav_ctrl.sv
// Maze navigation controller: debounced detectors, fork/block FSM, timed turns
// and an optional turn-history ring buffer enabled by AUTO_NAV_HIST_EN.
module auto_nav_ctrl
  import auto_nav_pkg::*;
#(
  parameter int  TICK_DIV   = 100000,
  parameter int  STABLE_MS  = 50,
  parameter int  TURN_MS    = 900,
  parameter int  LEFT_HAND  = 0,
  parameter int  HIST_DEPTH = 8,
  localparam int HIST_IW    = $clog2(HIST_DEPTH)
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               full_auto,
  input  logic               front_det,
  input  logic               left_det,
  input  logic               right_det,
  input  logic               move_forward_signal,
  input  logic               turn_left_signal,
  input  logic               turn_right_signal,
  output logic               move_forward,
  output logic               move_backward,
  output logic               turn_left,
  output logic               turn_right,
  output logic [2:0]         nav_state,
  input  logic [HIST_IW-1:0] hist_rd_idx,
  output logic [1:0]         hist_rd_data,
  output logic [HIST_IW:0]   hist_count
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int CW = $clog2(2 * TURN_MS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TURN_LIM  = CW'(TURN_MS);
  localparam logic [CW-1:0] UTURN_LIM = CW'(2 * TURN_MS);
  localparam dir_e          PREF_DIR  = (LEFT_HAND != 0) ? DIR_LEFT : DIR_RIGHT;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic          front_f, left_f, right_f;
  logic          left_open, right_open, pref_open, at_fork;

  nav_state_e    state_q, state_d;
  dir_e          dir_q, dir_d;
  logic          suppress_q, suppress_d;
  logic [CW-1:0] turn_cnt_q, turn_cnt_d;
  logic          log_en;
  hist_code_e    log_code;
  logic          mv_fwd_q, mv_fwd_d, tl_q, tl_d, tr_q, tr_d;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  det_filter #(.STABLE_MS(STABLE_MS)) u_front (
    .sys_clk(sys_clk), .rst(rst), .tick(tick), .det_raw(front_det), .det_filt(front_f));
  det_filter #(.STABLE_MS(STABLE_MS)) u_left (
    .sys_clk(sys_clk), .rst(rst), .tick(tick), .det_raw(left_det), .det_filt(left_f));
  det_filter #(.STABLE_MS(STABLE_MS)) u_right (
    .sys_clk(sys_clk), .rst(rst), .tick(tick), .det_raw(right_det), .det_filt(right_f));

  assign left_open  = ~left_f;
  assign right_open = ~right_f;
  assign pref_open  = (LEFT_HAND != 0) ? left_open : right_open;
  assign at_fork    = ~front_f & (left_open | right_open);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    suppress_d = suppress_q & at_fork;
    turn_cnt_d = '0;
    log_en     = 1'b0;
    log_code   = HIST_NONE;
    if (!enable) begin
      state_d    = ST_IDLE;
      suppress_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_MOVE;
          suppress_d = 1'b0;
        end
        ST_MOVE: begin
          if (front_f) begin
            state_d = ST_CHECK;
          end else if (at_fork && !suppress_q) begin
            if (!full_auto) begin
              state_d = ST_WAIT;
            end else if (pref_open) begin
              state_d = ST_TURN;
              dir_d   = PREF_DIR;
            end else begin
              suppress_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (left_open && right_open) begin
            state_d = ST_TURN;
            dir_d   = PREF_DIR;
          end else if (left_open) begin
            state_d = ST_TURN;
            dir_d   = DIR_LEFT;
          end else if (right_open) begin
            state_d = ST_TURN;
            dir_d   = DIR_RIGHT;
          end else begin
            state_d = ST_UTURN;
            dir_d   = DIR_LEFT;
          end
        end
        ST_WAIT: begin
          if (move_forward_signal) begin
            state_d    = ST_MOVE;
            suppress_d = 1'b1;
          end else if (turn_left_signal) begin
            state_d = ST_TURN;
            dir_d   = DIR_LEFT;
          end else if (turn_right_signal) begin
            state_d = ST_TURN;
            dir_d   = DIR_RIGHT;
          end
        end
        ST_TURN, ST_UTURN: begin
          turn_cnt_d = turn_cnt_q;
          if (tick) begin
            turn_cnt_d = turn_cnt_q + CW'(1);
            if (turn_cnt_d == ((state_q == ST_UTURN) ? UTURN_LIM : TURN_LIM)) begin
              state_d    = ST_MOVE;
              suppress_d = 1'b1;
              turn_cnt_d = '0;
              log_en     = 1'b1;
              log_code   = (state_q == ST_UTURN) ? HIST_U : dir_to_hist(dir_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mv_fwd_d = (state_q == ST_MOVE);
    tl_d     = ((state_q == ST_TURN) || (state_q == ST_UTURN)) && (dir_q == DIR_LEFT);
    tr_d     = ((state_q == ST_TURN) || (state_q == ST_UTURN)) && (dir_q == DIR_RIGHT);
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      state_q    <= ST_IDLE;
      dir_q      <= DIR_LEFT;
      suppress_q <= 1'b0;
      turn_cnt_q <= '0;
      mv_fwd_q   <= 1'b0;
      tl_q       <= 1'b0;
      tr_q       <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      dir_q      <= dir_d;
      suppress_q <= suppress_d;
      turn_cnt_q <= turn_cnt_d;
      mv_fwd_q   <= mv_fwd_d;
      tl_q       <= tl_d;
      tr_q       <= tr_d;
    end
  end

  assign nav_state     = state_q;
  assign move_forward  = mv_fwd_q;
  assign move_backward = 1'b0;
  assign turn_left     = tl_q;
  assign turn_right    = tr_q;

`ifdef AUTO_NAV_HIST_EN
  localparam int CNTW = HIST_IW + 1;
  localparam logic [CNTW-1:0] HIST_FULL = CNTW'(HIST_DEPTH);

  hist_code_e         hist_mem_q [HIST_DEPTH];
  hist_code_e         hist_mem_d [HIST_DEPTH];
  logic [HIST_IW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr;
  logic [CNTW-1:0]    hist_cnt_q, hist_cnt_d;

  always_comb begin
    hist_mem_d = hist_mem_q;
    wr_ptr_d   = wr_ptr_q;
    hist_cnt_d = hist_cnt_q;
    if (log_en) begin
      hist_mem_d[wr_ptr_q] = log_code;
      wr_ptr_d             = wr_ptr_q + HIST_IW'(1);
      if (hist_cnt_q != HIST_FULL) hist_cnt_d = hist_cnt_q + CNTW'(1);
    end
  end

  // NOTE: the history array is deliberately reset; it is a few flops and must read as empty after reset.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem_q[i] <= HIST_NONE;
      wr_ptr_q   <= '0;
      hist_cnt_q <= '0;
    end else begin
      hist_mem_q <= hist_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end

  // Index 0 is the newest entry, one behind the write pointer; depth is a power of two so wrap is free.
  assign rd_ptr       = wr_ptr_q - HIST_IW'(1) - hist_rd_idx;
  assign hist_rd_data = ({1'b0, hist_rd_idx} < hist_cnt_q) ? hist_mem_q[rd_ptr] : HIST_NONE;
  assign hist_count   = hist_cnt_q;
`else
  logic unused_hist;
  assign unused_hist  = ^{hist_rd_idx, log_en, log_code};
  assign hist_rd_data = 2'b00;
  assign hist_count   = '0;
`endif

endmodule
